// File: rtl/writeback_unit.sv
// writeback_unit: accepts one instruction result over valid/ready and issues a
// single-cycle register file write with the formatted (load-extended) value.
module writeback_unit #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                result_source,
  input  logic [XLEN-1:0]           alu_result,
  input  logic [XLEN-1:0]           load_data,
  input  logic [1:0]                load_address_low,
  input  logic [2:0]                load_funct3,
  input  logic [XLEN-1:0]           pc_plus_4,
  input  logic [XLEN-1:0]           immediate,
  input  logic [REG_ADDR_WIDTH-1:0] rd_in,
  input  logic                      flush,
  output logic                      write_enable,
  output logic [REG_ADDR_WIDTH-1:0] destination_register,
  output logic [XLEN-1:0]           destination_value,
  output logic                      writeback_done,
  output logic                      misaligned_error
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FORMAT = 2'd1,
    ST_WRITE  = 2'd2
  } state_e;

  localparam logic [1:0] SRC_ALU  = 2'd0;
  localparam logic [1:0] SRC_LOAD = 2'd1;
  localparam logic [1:0] SRC_PC4  = 2'd2;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  state_e                    state_q, state_d;
  logic                      in_ready_q, in_ready_d;
  logic                      write_enable_q, write_enable_d;
  logic [REG_ADDR_WIDTH-1:0] destination_register_q, destination_register_d;
  logic [XLEN-1:0]           destination_value_q, destination_value_d;
  logic                      writeback_done_q, writeback_done_d;
  logic                      misaligned_error_q, misaligned_error_d;

  logic [1:0]                cap_src_q, cap_src_d;
  logic [XLEN-1:0]           cap_alu_q, cap_alu_d;
  logic [XLEN-1:0]           cap_load_q, cap_load_d;
  logic [1:0]                cap_off_q, cap_off_d;
  logic [2:0]                cap_f3_q, cap_f3_d;
  logic [XLEN-1:0]           cap_pc_q, cap_pc_d;
  logic [XLEN-1:0]           cap_imm_q, cap_imm_d;
  logic [REG_ADDR_WIDTH-1:0] cap_rd_q, cap_rd_d;

  logic [7:0]                load_byte;
  logic [15:0]               load_half;
  logic [XLEN-1:0]           fmt_value;
  logic                      fmt_error;

  // Byte/halfword lane select from the captured load offset
  always_comb begin
    load_byte = cap_load_q[7:0];
    case (cap_off_q)
      2'd0:    load_byte = cap_load_q[7:0];
      2'd1:    load_byte = cap_load_q[15:8];
      2'd2:    load_byte = cap_load_q[23:16];
      default: load_byte = cap_load_q[31:24];
    endcase
    load_half = cap_off_q[1] ? cap_load_q[31:16] : cap_load_q[15:0];
  end

  // Result source mux, load extension and misalignment/illegal-funct3 check
  always_comb begin
    fmt_value = cap_alu_q;
    fmt_error = 1'b0;
    case (cap_src_q)
      SRC_ALU: fmt_value = cap_alu_q;
      SRC_LOAD: begin
        case (cap_f3_q)
          F3_LB:  fmt_value = {{(XLEN-8){load_byte[7]}}, load_byte};
          F3_LH:  begin
            fmt_value = {{(XLEN-16){load_half[15]}}, load_half};
            fmt_error = cap_off_q[0];
          end
          F3_LW:  begin
            fmt_value = cap_load_q;
            fmt_error = (cap_off_q != 2'd0);
          end
          F3_LBU: fmt_value = {{(XLEN-8){1'b0}}, load_byte};
          F3_LHU: begin
            fmt_value = {{(XLEN-16){1'b0}}, load_half};
            fmt_error = cap_off_q[0];
          end
          default: begin
            fmt_value = cap_load_q;
            fmt_error = 1'b1;
          end
        endcase
      end
      SRC_PC4: fmt_value = cap_pc_q;
      default: fmt_value = cap_imm_q;
    endcase
  end

  // Next-state and registered-output logic; strobes default low every cycle
  always_comb begin
    state_d                = state_q;
    in_ready_d             = in_ready_q;
    write_enable_d         = 1'b0;
    writeback_done_d       = 1'b0;
    misaligned_error_d     = 1'b0;
    destination_register_d = destination_register_q;
    destination_value_d    = destination_value_q;
    cap_src_d              = cap_src_q;
    cap_alu_d              = cap_alu_q;
    cap_load_d             = cap_load_q;
    cap_off_d              = cap_off_q;
    cap_f3_d               = cap_f3_q;
    cap_pc_d               = cap_pc_q;
    cap_imm_d              = cap_imm_q;
    cap_rd_d               = cap_rd_q;

    case (state_q)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && !flush) begin
          cap_src_d  = result_source;
          cap_alu_d  = alu_result;
          cap_load_d = load_data;
          cap_off_d  = load_address_low;
          cap_f3_d   = load_funct3;
          cap_pc_d   = pc_plus_4;
          cap_imm_d  = immediate;
          cap_rd_d   = rd_in;
          in_ready_d = 1'b0;
          state_d    = ST_FORMAT;
        end
      end
      ST_FORMAT: begin
        if (flush) begin
          in_ready_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          destination_value_d    = fmt_value;
          destination_register_d = cap_rd_q;
          write_enable_d         = !fmt_error && (cap_rd_q != '0);
          writeback_done_d       = 1'b1;
          misaligned_error_d     = fmt_error;
          state_d                = ST_WRITE;
        end
      end
      ST_WRITE: begin
        in_ready_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        in_ready_d = 1'b1;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q                <= ST_IDLE;
      in_ready_q             <= 1'b1;
      write_enable_q         <= 1'b0;
      writeback_done_q       <= 1'b0;
      misaligned_error_q     <= 1'b0;
      destination_register_q <= '0;
      destination_value_q    <= '0;
      cap_src_q              <= '0;
      cap_alu_q              <= '0;
      cap_load_q             <= '0;
      cap_off_q              <= '0;
      cap_f3_q               <= '0;
      cap_pc_q               <= '0;
      cap_imm_q              <= '0;
      cap_rd_q               <= '0;
    end else begin
      state_q                <= state_d;
      in_ready_q             <= in_ready_d;
      write_enable_q         <= write_enable_d;
      writeback_done_q       <= writeback_done_d;
      misaligned_error_q     <= misaligned_error_d;
      destination_register_q <= destination_register_d;
      destination_value_q    <= destination_value_d;
      cap_src_q              <= cap_src_d;
      cap_alu_q              <= cap_alu_d;
      cap_load_q             <= cap_load_d;
      cap_off_q              <= cap_off_d;
      cap_f3_q               <= cap_f3_d;
      cap_pc_q               <= cap_pc_d;
      cap_imm_q              <= cap_imm_d;
      cap_rd_q               <= cap_rd_d;
    end
  end

  assign in_ready             = in_ready_q;
  assign write_enable         = write_enable_q;
  assign destination_register = destination_register_q;
  assign destination_value    = destination_value_q;
  assign writeback_done       = writeback_done_q;
  assign misaligned_error     = misaligned_error_q;

endmodule
